// File: rtl/hex_scan_ctrl.sv
// hex_scan_ctrl: time-multiplexed scan driver for multi-digit seven-segment
// displays sharing one segment bus. Each digit slot is BlankCycles of
// all-off (anti-ghosting) followed by TickDiv-BlankCycles drive cycles.
// Optional PWM dimming is enabled by defining HEX_SCAN_BRIGHTNESS_EN;
// without it the brightness port is ignored and segments stay lit for the
// whole drive window.
module hex_scan_ctrl #(
   parameter int unsigned NumDigits    = 4,
   parameter int unsigned TickDiv      = 1024,
   parameter int unsigned BlankCycles  = 16,
   parameter bit          SegActiveLow = 1'b1,
   parameter bit          AnActiveLow  = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic [7*NumDigits-1:0] dig_in,
   input  logic [3:0]             brightness,
   output logic [6:0]             seg,
   output logic [NumDigits-1:0]   an,
   output logic [((NumDigits > 1) ? $clog2(NumDigits) : 1)-1:0] scan_idx,
   output logic                   frame_done
);

   localparam int unsigned IdxW     = (NumDigits > 1) ? $clog2(NumDigits) : 1;
   localparam int unsigned CntW     = $clog2(TickDiv);
   localparam int unsigned SnapW    = 7 * NumDigits;

   localparam logic [IdxW-1:0]      LastIdx    = IdxW'(NumDigits - 1);
   localparam logic [CntW-1:0]      LastCnt    = CntW'(TickDiv - 1);
   localparam logic [CntW-1:0]      BlankLast  = CntW'(BlankCycles - 1);
   localparam logic [6:0]           SegOff     = {7{SegActiveLow}};
   localparam logic [NumDigits-1:0] AnOff      = {NumDigits{AnActiveLow}};

`ifdef HEX_SCAN_BRIGHTNESS_EN
   localparam int unsigned DriveLen = TickDiv - BlankCycles;
   localparam int unsigned LitW     = $clog2(16 * TickDiv + 1) + 1;
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } state_e;

   // A zero-length blank window means every slot opens directly in DRIVE.
   localparam state_e SlotStart = (BlankCycles == 0) ? DRIVE : BLANK;

   state_e           state_q, state_d;
   logic [CntW-1:0]  slot_cnt_q, slot_cnt_d;
   logic [IdxW-1:0]  scan_idx_q, scan_idx_d;
   logic [SnapW-1:0] dig_snap_q, dig_snap_d;
   logic [6:0]       seg_q, seg_d;
   logic [NumDigits-1:0] an_q, an_d;
   logic             frame_done_q, frame_done_d;

`ifdef HEX_SCAN_BRIGHTNESS_EN
   logic [3:0]       bright_snap_q, bright_snap_d;
`else
   logic             unused_brightness;
   assign unused_brightness = ^brightness;
`endif

   // Slot sequencing: state, slot counter, digit index and frame snapshot.
   always_comb begin
      state_d    = state_q;
      slot_cnt_d = slot_cnt_q;
      scan_idx_d = scan_idx_q;
      dig_snap_d = dig_snap_q;
`ifdef HEX_SCAN_BRIGHTNESS_EN
      bright_snap_d = bright_snap_q;
`endif
      if (!enable) begin
         state_d    = IDLE;
         slot_cnt_d = '0;
         scan_idx_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d    = SlotStart;
               slot_cnt_d = '0;
               scan_idx_d = '0;
               dig_snap_d = dig_in;
`ifdef HEX_SCAN_BRIGHTNESS_EN
               bright_snap_d = brightness;
`endif
            end
            BLANK: begin
               slot_cnt_d = slot_cnt_q + CntW'(1);
               if (slot_cnt_q == BlankLast) begin
                  state_d = DRIVE;
               end
            end
            DRIVE: begin
               if (slot_cnt_q == LastCnt) begin
                  slot_cnt_d = '0;
                  state_d    = SlotStart;
                  if (scan_idx_q == LastIdx) begin
                     // Frame boundary: the only point the snapshot may change.
                     scan_idx_d = '0;
                     dig_snap_d = dig_in;
`ifdef HEX_SCAN_BRIGHTNESS_EN
                     bright_snap_d = brightness;
`endif
                  end else begin
                     scan_idx_d = scan_idx_q + IdxW'(1);
                  end
               end else begin
                  slot_cnt_d = slot_cnt_q + CntW'(1);
               end
            end
            default: begin
               state_d    = IDLE;
               slot_cnt_d = '0;
               scan_idx_d = '0;
            end
         endcase
      end
   end

   // Pin decode from next-state values so the pins come straight off flops.
   always_comb begin
      logic [6:0]           seg_on;
      logic [6:0]           seg_sel;
      logic [NumDigits-1:0] an_on;
      logic                 lit;
`ifdef HEX_SCAN_BRIGHTNESS_EN
      logic [CntW-1:0]      drive_idx;
      drive_idx = slot_cnt_d - CntW'(BlankCycles);
      lit = (LitW'(drive_idx) * LitW'(16)) <
            (LitW'(DriveLen) * (LitW'(bright_snap_d) + LitW'(1)));
`else
      lit = 1'b1;
`endif
      seg_on       = '0;
      seg_sel      = '0;
      an_on        = '0;
      frame_done_d = 1'b0;
      if (state_d == DRIVE) begin
         for (int unsigned i = 0; i < NumDigits; i++) begin
            if (scan_idx_d == IdxW'(i)) begin
               an_on[i] = 1'b1;
               seg_sel  = dig_snap_d[7*i +: 7];
            end
         end
         seg_on       = lit ? seg_sel : 7'h00;
         frame_done_d = (slot_cnt_d == LastCnt) && (scan_idx_d == LastIdx);
      end
      seg_d = SegActiveLow ? ~seg_on : seg_on;
      an_d  = AnActiveLow  ? ~an_on  : an_on;
   end

   // State and output registers, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         slot_cnt_q   <= '0;
         scan_idx_q   <= '0;
         dig_snap_q   <= '0;
         seg_q        <= SegOff;
         an_q         <= AnOff;
         frame_done_q <= 1'b0;
`ifdef HEX_SCAN_BRIGHTNESS_EN
         bright_snap_q <= '0;
`endif
      end else begin
         state_q      <= state_d;
         slot_cnt_q   <= slot_cnt_d;
         scan_idx_q   <= scan_idx_d;
         dig_snap_q   <= dig_snap_d;
         seg_q        <= seg_d;
         an_q         <= an_d;
         frame_done_q <= frame_done_d;
`ifdef HEX_SCAN_BRIGHTNESS_EN
         bright_snap_q <= bright_snap_d;
`endif
      end
   end

   assign seg        = seg_q;
   assign an         = an_q;
   assign scan_idx   = scan_idx_q;
   assign frame_done = frame_done_q;

endmodule
